// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch front end. It issues sequential word fetches to the
// instruction memory with at most one request in flight, and buffers the
// returned {pc, instr} pairs in a small circular FIFO that feeds decode.
// A redirect from the PC select stage flushes the FIFO and restarts fetch
// at the (word-aligned) target. A response belonging to a request that
// was issued before the redirect is dropped when it arrives.
//
// Parameters:
//   RESET_PC        fetch address used after reset
//   DEPTH           number of FIFO entries (power of two, >= 2)
//
// Ports:
//   clk             single clock, rising edge
//   rst             synchronous active-high reset
//   redirect_valid  next-PC override from the PC select stage
//   redirect_pc     redirect target (low two bits ignored)
//   imem_req_valid  fetch request valid
//   imem_req_addr   fetch word address
//   imem_req_ready  memory accepts the request
//   imem_resp_valid instruction word returned
//   imem_resp_data  instruction word
//   out_valid       head entry valid to decode
//   out_pc          PC of the head entry
//   out_instr       instruction of the head entry
//   out_ready       decode consumes the head
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic             outstanding;
    logic             drop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic issue;
    logic resp_hit;
    logic push;
    logic pop;

    // Handshake decode. Issue is held off while a request is in flight or
    // while the FIFO has no room for its eventual response, which is what
    // keeps count + outstanding within DEPTH. A redirect or reset suppresses
    // both the request and the decode-side valid in the same cycle.
    always_comb begin
        imem_req_valid = !rst && !outstanding && (count < FULL_COUNT) && !redirect_valid;
        imem_req_addr  = fetch_pc;
        out_valid      = !rst && (count != '0) && !redirect_valid;
        out_pc         = pc_mem[rd_ptr];
        out_instr      = instr_mem[rd_ptr];
        issue          = imem_req_valid && imem_req_ready;
        resp_hit       = imem_resp_valid && outstanding;
        push           = !rst && resp_hit && !drop && !redirect_valid;
        pop            = out_valid && out_ready;
    end

    // Control state. Reset beats everything; a redirect beats push, pop and
    // issue. A redirect with a request still in flight marks that request
    // for dropping, unless its response lands in the same cycle, in which
    // case the response is simply discarded and nothing is left pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            if (outstanding) begin
                if (imem_resp_valid) begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end else begin
                    drop <= 1'b1;
                end
            end
        end else begin
            if (issue) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (resp_hit) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. Entries need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Directed bench for instr_fetch_queue with DEPTH = 2 and RESET_PC = 0.
// Inputs are driven on the falling edge and outputs are sampled 1 ns later,
// so every check sees the combinational view of the cycle that the next
// rising edge will commit. Each scenario starts from a reset cycle.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    int vec_count;
    int miscompare_count;

    instr_fetch_queue #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's worth of inputs on the falling edge, then settle.
    task automatic applyStimulus(input logic        r,
                                 input logic        rv,
                                 input logic [31:0] rpc,
                                 input logic        rq_rdy,
                                 input logic        rsp_v,
                                 input logic [31:0] rsp_d,
                                 input logic        o_rdy);
        @(negedge clk);
        rst             = r;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_req_ready  = rq_rdy;
        imem_resp_valid = rsp_v;
        imem_resp_data  = rsp_d;
        out_ready       = o_rdy;
        #1;
    endtask

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic resetCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        vec_count        = 0;
        miscompare_count = 0;
        rst              = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        imem_req_ready   = 1'b0;
        imem_resp_valid  = 1'b0;
        imem_resp_data   = 32'h0;
        out_ready        = 1'b0;

        // ---------------- streaming ----------------
        $display("[TB] streaming");
        resetCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("st_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("st_first_req_addr", imem_req_addr, 32'h0);
        checkOutput("st_empty_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0013, 1'b1);
        checkOutput("st_busy_req_valid", {31'b0, imem_req_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("st_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("st_out_pc", out_pc, 32'(i * 4));
            checkOutput("st_out_instr", out_instr, 32'h0000_0013);
            checkOutput("st_req_addr", imem_req_addr, 32'(i * 4 + 4));
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0013, 1'b1);
            checkOutput("st_pop_out_valid", {31'b0, out_valid}, 32'd0);
        end

        // ---------------- backpressure ----------------
        $display("[TB] backpressure");
        resetCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("bp_req_addr0", imem_req_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA000_0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("bp_req_valid1", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("bp_req_addr1", imem_req_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA000_0004, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput("bp_full_req_valid", {31'b0, imem_req_valid}, 32'd0);
            checkOutput("bp_full_out_pc", out_pc, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_drain0_pc", out_pc, 32'h0);
        checkOutput("bp_drain0_instr", out_instr, 32'hA000_0000);
        checkOutput("bp_drain0_req_valid", {31'b0, imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_drain1_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_drain1_pc", out_pc, 32'h4);
        checkOutput("bp_drain1_instr", out_instr, 32'hA000_0004);
        checkOutput("bp_resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("bp_resume_req_addr", imem_req_addr, 32'h8);

        // ---------------- redirect with request in flight ----------------
        $display("[TB] redirect in flight");
        resetCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0004, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rf_req_addr8", imem_req_addr, 32'h8);
        checkOutput("rf_pc4_valid", {31'b0, out_valid}, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rf_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rf_redir_out_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0008, 1'b1);
        checkOutput("rf_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rf_dropped_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rf_target_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("rf_target_req_addr", imem_req_addr, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0100, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rf_first_out_pc", out_pc, 32'h100);
        checkOutput("rf_first_out_instr", out_instr, 32'h1111_0100);

        // ---------------- redirect coinciding with response ----------------
        $display("[TB] redirect with response");
        resetCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'hBAD0_0000, 1'b1);
        checkOutput("rc_same_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rc_same_req_valid", {31'b0, imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rc_after_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rc_after_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("rc_after_req_addr", imem_req_addr, 32'h40);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_0040, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rc_next_out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("rc_next_out_pc", out_pc, 32'h40);
        checkOutput("rc_next_out_instr", out_instr, 32'h6666_0040);

        // ---------------- misaligned redirect target ----------------
        $display("[TB] misaligned target");
        resetCycle();
        applyStimulus(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("ma_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("ma_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("ma_req_addr", imem_req_addr, 32'h200);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_0200, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("ma_out_pc", out_pc, 32'h200);
        checkOutput("ma_out_instr", out_instr, 32'h7777_0200);

        // ---------------- reset with capacity committed ----------------
        // With DEPTH = 2 one buffered entry plus one in-flight request is
        // the fullest legal state.
        $display("[TB] reset mid-operation");
        resetCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hCCCC_0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("rs_pre_req_addr", imem_req_addr, 32'h4);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("rs_rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rs_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCCCC_0004, 1'b0);
        checkOutput("rs_late_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rs_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("rs_first_req_addr", imem_req_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rs_ignored_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rs_still_req_addr", imem_req_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
